// File: rtl/div_serial.sv
// Iterative restoring divider resolving BITS_PER_CYCLE quotient bits per clock, with valid/ready handshake.
// Optional DIV_FAST_ZERO_EN: a zero divisor skips the iteration phase and reports after two edges.
module div_serial #(
  parameter int DATA_W         = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero
);

  localparam int N     = DATA_W / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [DATA_W-1:0]  a_reg;
  logic [DATA_W-1:0]  b_reg;
  logic [DATA_W-1:0]  rem_reg;
  logic [DATA_W-1:0]  quo_reg;
  logic [DATA_W-1:0]  orig_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic               zero_reg;

  logic               accept;
  logic               dvd_neg;
  logic               dvs_neg;
  logic [DATA_W-1:0]  dvd_mag;
  logic [DATA_W-1:0]  dvs_mag;
  state_t             accept_state;

  assign in_ready = (state_reg == IDLE) || (state_reg == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  assign dvd_neg = signed_i && dividend[DATA_W-1];
  assign dvs_neg = signed_i && divisor[DATA_W-1];
  assign dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
  assign dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;

`ifdef DIV_FAST_ZERO_EN
  assign accept_state = (divisor == '0) ? FIX : CALC;
`else
  assign accept_state = CALC;
`endif

  // Unrolled chain of restoring steps; each stage consumes one dividend bit MSB first.
  logic [DATA_W-1:0] rem_c [BITS_PER_CYCLE+1];
  logic [DATA_W-1:0] a_c   [BITS_PER_CYCLE+1];
  logic [DATA_W-1:0] q_c   [BITS_PER_CYCLE+1];

  assign rem_c[0] = rem_reg;
  assign a_c[0]   = a_reg;
  assign q_c[0]   = quo_reg;

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
      logic [DATA_W:0] shifted;
      logic [DATA_W:0] trial;
      assign shifted = {rem_c[gi], a_c[gi][DATA_W-1]};
      assign trial   = shifted - {1'b0, b_reg};
      // A set top bit of trial is the borrow: keep the shifted remainder.
      assign rem_c[gi+1] = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
      assign a_c[gi+1]   = a_c[gi] << 1;
      assign q_c[gi+1]   = (q_c[gi] << 1) | {{(DATA_W-1){1'b0}}, ~trial[DATA_W]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (state_reg == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        a_reg     <= dvd_mag;
        b_reg     <= dvs_mag;
        orig_reg  <= dividend;
        neg_q_reg <= dvd_neg ^ dvs_neg;
        neg_r_reg <= dvd_neg;
        zero_reg  <= (divisor == '0);
        rem_reg   <= '0;
        quo_reg   <= '0;
        cnt_reg   <= '0;
        state_reg <= accept_state;
      end else begin
        case (state_reg)
          CALC: begin
            rem_reg <= rem_c[BITS_PER_CYCLE];
            a_reg   <= a_c[BITS_PER_CYCLE];
            quo_reg <= q_c[BITS_PER_CYCLE];
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(N - 1)) begin
              state_reg <= FIX;
            end
          end
          FIX: begin
            if (zero_reg) begin
              quotient    <= '1;
              remainder   <= orig_reg;
              div_by_zero <= 1'b1;
            end else begin
              quotient    <= neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
              remainder   <= neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
              div_by_zero <= 1'b0;
            end
            out_valid <= 1'b1;
            state_reg <= DONE;
          end
          DONE: begin
            if (out_ready) begin
              state_reg <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
